// File: rtl/mux8_sched_pkg.sv
// Shared constants and state type for the 8-way round-robin
// burst scheduler.
package mux8_sched_pkg;
  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;
endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr,
// ascending with wrap 7->0.
module rr_pick
  import mux8_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr + SEL_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_sched.sv
// 8:1 bit mux with round-robin grant and bounded bursts;
// grant, select and data are all registered.
module mux8_rr_sched
  import mux8_sched_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] din,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             dout,
  output logic             dvalid
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             dout_q, dout_d;
  logic             dvalid_q, dvalid_d;

  logic [SEL_W-1:0] nxt_sel;
  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic [CNT_W-1:0] cnt_inc;
  logic             xfer;
  logic             rel;

  assign nxt_sel = sel_q + SEL_W'(1);
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign xfer    = (state_q == GRANT) && req[sel_q];
  assign rel     = (state_q == GRANT) &&
                   (!req[sel_q] || (cnt_inc == MAX_CNT));

  // Starting one past the holder makes it the last candidate.
  assign pick_ptr = (state_q == GRANT) ? nxt_sel : ptr_q;

  rr_pick u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          dout_d   = din[sel_q];
          dvalid_d = 1'b1;
          cnt_d    = cnt_inc;
        end
        if (rel) begin
          ptr_d = nxt_sel;
          cnt_d = '0;
          if (pick_found) begin
            sel_d = pick_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
    gnt_d = (state_d == GRANT) ? (N_REQ'(1) << sel_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      dout_q   <= 1'b0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign gnt    = gnt_q;
  assign sel    = sel_q;
  assign busy   = (state_q == GRANT);
  assign dout   = dout_q;
  assign dvalid = dvalid_q;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Vector table plus scoreboard bench for mux8_rr_sched,
// default burst and MAX_BURST=1 instances.
module tb_mux8_rr_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req0 = '0, din0 = '0;
  logic [7:0] req1 = '0, din1 = '0;
  logic [7:0] gnt0, gnt1;
  logic [2:0] sel0, sel1;
  logic       busy0, busy1, dout0, dout1, dv0, dv1;

  always #5 clk = ~clk;

  mux8_rr_sched #(.MAX_BURST(4)) u0 (
    .clk(clk), .rst(rst), .req(req0), .din(din0),
    .gnt(gnt0), .sel(sel0), .busy(busy0),
    .dout(dout0), .dvalid(dv0)
  );

  mux8_rr_sched #(.MAX_BURST(1)) u1 (
    .clk(clk), .rst(rst), .req(req1), .din(din1),
    .gnt(gnt1), .sel(sel1), .busy(busy1),
    .dout(dout1), .dvalid(dv1)
  );

  typedef struct {
    bit         rst_b;
    bit         inst;
    logic [7:0] req;
    logic [7:0] din;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       dvalid;
    logic       dout;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic vec_t mk(bit r, bit i,
                              logic [7:0] rq, logic [7:0] dn,
                              logic [7:0] g, logic [2:0] s,
                              logic b, logic v, logic o);
    vec_t t;
    t.rst_b = r; t.inst = i; t.req = rq; t.din = dn;
    t.gnt = g; t.sel = s; t.busy = b; t.dvalid = v; t.dout = o;
    return t;
  endfunction

  task automatic check_pop(input string tag);
    vec_t       e;
    logic [7:0] g;
    logic [2:0] s;
    logic       b, v, o;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    if (e.inst) begin
      g = gnt1; s = sel1; b = busy1; v = dv1; o = dout1;
    end else begin
      g = gnt0; s = sel0; b = busy0; v = dv0; o = dout0;
    end
    if ({g, s, b, v, o} !== {e.gnt, e.sel, e.busy, e.dvalid, e.dout}) begin
      n_fail++;
      $display("FAIL %s got gnt=%h sel=%0d busy=%b dvalid=%b dout=%b want gnt=%h sel=%0d busy=%b dvalid=%b dout=%b",
               tag, g, s, b, v, o,
               e.gnt, e.sel, e.busy, e.dvalid, e.dout);
    end
  endtask

  task automatic expect_v(input bit i, input logic [7:0] g,
                          input logic [2:0] s, input logic b,
                          input logic v, input logic o);
    sb.push_back(mk(1'b0, i, 8'h00, 8'h00, g, s, b, v, o));
  endtask

  task automatic drive(input bit i, input logic [7:0] rq,
                       input logic [7:0] dn);
    if (i) begin
      req1 = rq; din1 = dn; req0 = '0; din0 = '0;
    end else begin
      req0 = rq; din0 = dn; req1 = '0; din1 = '0;
    end
  endtask

  // Called at a negedge; ends at a negedge with rst low.
  task automatic do_reset();
    rst = 1'b1;
    req0 = '0; din0 = '0; req1 = '0; din1 = '0;
    #1;
    expect_v(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    check_pop("reset_u0");
    expect_v(1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    check_pop("reset_u1");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    logic [2:0] s;
    // single requester 2, regranted after its burst
    tbl.push_back(mk(1, 0, 8'h04, 8'h04, 8'h04, 3'd2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h04, 8'h04, 8'h04, 3'd2, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h04, 8'h04, 8'h04, 3'd2, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h04, 8'h04, 8'h04, 3'd2, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h04, 8'h04, 8'h04, 3'd2, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h04, 8'h04, 8'h04, 3'd2, 1, 1, 1));
    // 0 and 7 alternate bursts with no idle gap
    tbl.push_back(mk(1, 0, 8'h81, 8'h80, 8'h01, 3'd0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h81, 8'h80, 8'h01, 3'd0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h81, 8'h80, 8'h01, 3'd0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h81, 8'h80, 8'h01, 3'd0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h81, 8'h80, 8'h80, 3'd7, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'h81, 8'h80, 8'h80, 3'd7, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h81, 8'h80, 8'h80, 3'd7, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h81, 8'h80, 8'h80, 3'd7, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h81, 8'h80, 8'h01, 3'd0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h81, 8'h80, 8'h01, 3'd0, 1, 1, 0));
    // holder 3 drops after 2 beats; ptr then favours 4 over 3
    tbl.push_back(mk(1, 0, 8'h08, 8'h08, 8'h08, 3'd3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h08, 8'h08, 8'h08, 3'd3, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h08, 8'h08, 8'h08, 3'd3, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h08, 8'h00, 3'd3, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h18, 8'h00, 8'h10, 3'd4, 1, 0, 1));
    // wrap past 7 from holder 6 to requester 1
    tbl.push_back(mk(1, 0, 8'h40, 8'h40, 8'h40, 3'd6, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h42, 8'h40, 8'h40, 3'd6, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h42, 8'h40, 8'h40, 3'd6, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h42, 8'h40, 8'h40, 3'd6, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h42, 8'h40, 8'h02, 3'd1, 1, 1, 1));
    tbl.push_back(mk(0, 0, 8'h42, 8'h40, 8'h02, 3'd1, 1, 1, 0));
    // MAX_BURST=1, everyone requesting: one beat per grant
    pat = 8'hAA;
    for (int k = 1; k <= 10; k++) begin
      s = 3'((k - 1) % 8);
      if (k == 1)
        tbl.push_back(mk(1, 1, 8'hFF, pat, 8'h01, 3'd0, 1, 0, 0));
      else
        tbl.push_back(mk(0, 1, 8'hFF, pat, 8'h01 << s, s, 1, 1,
                         pat[(k - 2) % 8]));
    end

    @(negedge clk);
    foreach (tbl[n]) begin
      if (tbl[n].rst_b) do_reset();
      drive(tbl[n].inst, tbl[n].req, tbl[n].din);
      sb.push_back(tbl[n]);
      @(posedge clk);
      #1;
      check_pop($sformatf("vec%0d", n));
      @(negedge clk);
    end

    // asynchronous reset in the middle of a burst
    do_reset();
    drive(1'b0, 8'h01, 8'h01);
    expect_v(1'b0, 8'h01, 3'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_pop("async_grant");
    expect_v(1'b0, 8'h01, 3'd0, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check_pop("async_beat");
    #2;
    rst = 1'b1;
    expect_v(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check_pop("async_rst");
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 8'h10, 8'h00);
    expect_v(1'b0, 8'h10, 3'd4, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_pop("post_rst_grant");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
